// File: rtl/miinst_issuer_if.sv
// Micro-instruction types, slot layout and the issuer handshake interface.
// Slot layout macros (MQ_N, MQ_*) may be predefined by the including build.
`ifndef MQ_N
`define MQ_N 6
`endif
`ifndef MQ_LOAD
`define MQ_LOAD 0
`endif
`ifndef MQ_ARITH
`define MQ_ARITH 1
`endif
`ifndef MQ_STORE
`define MQ_STORE 2
`endif
`ifndef MQ_RSRV1
`define MQ_RSRV1 3
`endif
`ifndef MQ_RSRV2
`define MQ_RSRV2 4
`endif
`ifndef MQ_RSRV3
`define MQ_RSRV3 5
`endif

package miinst_pkg;
    typedef logic [3:0] miop_t;
    localparam miop_t MIOP_NOP = 4'd0;

    typedef struct packed {
        miop_t       op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [15:0] imm;
    } miinst_t;
endpackage

// Both channels are valid/ready: a transfer happens on a rising edge where
// valid && ready; the sender holds its payload and valid stable until then.
interface miinst_issuer_if #(parameter int MQ_N = `MQ_N);
    logic                                bundle_valid;
    logic                                bundle_ready;
    miinst_pkg::miinst_t [MQ_N-1:0]      bundle;
    logic                                issue_valid;
    logic                                issue_ready;
    miinst_pkg::miinst_t                 issue;
    logic                                issue_last;
    logic                                flush;
    logic                                busy;

    modport slave (
        input  bundle_valid, bundle, issue_ready, flush,
        output bundle_ready, issue_valid, issue, issue_last, busy
    );

    modport master (
        output bundle_valid, bundle, issue_ready, flush,
        input  bundle_ready, issue_valid, issue, issue_last, busy
    );
endinterface

// File: rtl/miinst_issuer.sv
// Serialises a decoded bundle of micro-ops onto a single issue port, lowest slot first.
// Optional feature macro: ISSUER_SKID_EN adds a one-bundle skid buffer for gapless bundles.
`ifndef MQ_N
`define MQ_N 6
`endif

module miinst_issuer
    import miinst_pkg::*;
#(
    parameter int MQ_N = `MQ_N
) (
    input  logic            clk,
    input  logic            rstn,
    miinst_issuer_if.slave  bus,
    output logic            o_dbg_state
);
    localparam int IW = (MQ_N > 1) ? $clog2(MQ_N) : 1;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

    state_e              r_state, w_state_nxt;
    miinst_t [MQ_N-1:0]  r_buf, w_buf_nxt;
    logic [MQ_N-1:0]     r_pend, w_pend_nxt;
    logic [MQ_N-1:0]     w_in_mask;
    logic [MQ_N-1:0]     w_sel_oh;
    logic [MQ_N-1:0]     w_pend_left;
    logic [IW-1:0]       w_sel_idx;
    logic                w_acc;
    logic                w_hs;
    logic                w_last;

    always_comb begin
        w_in_mask = '0;
        for (int i = 0; i < MQ_N; i++) begin
            w_in_mask[i] = (bus.bundle[i].op != MIOP_NOP);
        end
    end

    // Lowest pending slot wins; one-hot form makes the "only one left" test cheap.
    always_comb begin
        w_sel_idx = '0;
        for (int i = MQ_N - 1; i >= 0; i--) begin
            if (r_pend[i]) w_sel_idx = IW'(i);
        end
    end

    assign w_sel_oh    = r_pend & (-r_pend);
    assign w_pend_left = r_pend & ~w_sel_oh;
    assign w_last      = (w_pend_left == '0);

    assign bus.issue_valid = (r_state == ISSUE);
    assign bus.issue       = (r_state == ISSUE) ? r_buf[w_sel_idx] : '0;
    assign bus.issue_last  = (r_state == ISSUE) && w_last;
    assign o_dbg_state     = (r_state == ISSUE);

    assign w_hs  = bus.issue_valid && bus.issue_ready;
    assign w_acc = bus.bundle_valid && bus.bundle_ready;

`ifdef ISSUER_SKID_EN
    miinst_t [MQ_N-1:0]  r_skid, w_skid_nxt;
    logic                r_skid_full, w_skid_full_nxt;
    logic [MQ_N-1:0]     w_skid_mask;

    always_comb begin
        w_skid_mask = '0;
        for (int i = 0; i < MQ_N; i++) begin
            w_skid_mask[i] = (r_skid[i].op != MIOP_NOP);
        end
    end

    assign bus.bundle_ready = rstn && !r_skid_full && !bus.flush;
    assign bus.busy         = (r_state == ISSUE) || r_skid_full;
`else
    assign bus.bundle_ready = rstn && (r_state == IDLE) && !bus.flush;
    assign bus.busy         = (r_state == ISSUE);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_pend_nxt  = r_pend;
`ifdef ISSUER_SKID_EN
        w_skid_nxt      = r_skid;
        w_skid_full_nxt = r_skid_full;
`endif
        if (bus.flush) begin
            // A handshake in the flush cycle is already consumed downstream.
            w_state_nxt = IDLE;
            w_buf_nxt   = '0;
            w_pend_nxt  = '0;
`ifdef ISSUER_SKID_EN
            w_skid_nxt      = '0;
            w_skid_full_nxt = 1'b0;
`endif
        end else if (r_state == IDLE) begin
            if (w_acc) begin
                w_buf_nxt  = bus.bundle;
                w_pend_nxt = w_in_mask;
                if (w_in_mask != '0) w_state_nxt = ISSUE;
            end
        end else begin
            if (w_hs) w_pend_nxt = w_pend_left;
            if (w_hs && w_last) begin
                w_state_nxt = IDLE;
`ifdef ISSUER_SKID_EN
                if (r_skid_full) begin
                    w_buf_nxt       = r_skid;
                    w_pend_nxt      = w_skid_mask;
                    w_skid_full_nxt = 1'b0;
                    if (w_skid_mask != '0) w_state_nxt = ISSUE;
                end else if (w_acc) begin
                    w_buf_nxt  = bus.bundle;
                    w_pend_nxt = w_in_mask;
                    if (w_in_mask != '0) w_state_nxt = ISSUE;
                end
`endif
            end
`ifdef ISSUER_SKID_EN
            else if (w_acc) begin
                w_skid_nxt      = bus.bundle;
                w_skid_full_nxt = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_pend  <= '0;
`ifdef ISSUER_SKID_EN
            r_skid      <= '0;
            r_skid_full <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_pend  <= w_pend_nxt;
`ifdef ISSUER_SKID_EN
            r_skid      <= w_skid_nxt;
            r_skid_full <= w_skid_full_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_miinst_issuer.sv
// Bench for miinst_issuer: directed scenarios plus a randomized run against a slot-order model.
// Expected issue stream is built from each accepted bundle's non-NOP slots in ascending index.
`timescale 1ns/1ps
`ifndef MQ_N
`define MQ_N 6
`endif
`ifndef MQ_LOAD
`define MQ_LOAD 0
`endif
`ifndef MQ_ARITH
`define MQ_ARITH 1
`endif
`ifndef MQ_STORE
`define MQ_STORE 2
`endif
`ifndef MQ_RSRV1
`define MQ_RSRV1 3
`endif
`ifndef MQ_RSRV2
`define MQ_RSRV2 4
`endif
`ifndef MQ_RSRV3
`define MQ_RSRV3 5
`endif

module tb_miinst_issuer;
    import miinst_pkg::*;

    localparam int N = `MQ_N;
    localparam int W = $bits(miinst_t) + 1;
    typedef miinst_t [N-1:0] bundle_t;

    logic clk;
    logic rstn;
    logic dbg_state;
    int   checks;
    int   errors;
    logic [W-1:0] exp_q[$];

    miinst_issuer_if #(.MQ_N(N)) bus();

    miinst_issuer #(.MQ_N(N)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        bus.bundle_valid = 1'b0;
        bus.bundle       = '0;
        bus.issue_ready  = 1'b0;
        bus.flush        = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic miinst_t rand_inst(input bit nop);
        miinst_t m;
        m.op  = nop ? MIOP_NOP : miop_t'($urandom_range(1, 15));
        m.rd  = 5'($urandom_range(0, 31));
        m.rs  = 5'($urandom_range(0, 31));
        m.imm = 16'($urandom);
        return m;
    endfunction

    function automatic bundle_t nop_bundle();
        bundle_t b;
        for (int i = 0; i < N; i++) b[i] = rand_inst(1'b1);
        return b;
    endfunction

    // Reference model: issue stream = non-NOP slots ascending, last flag on the highest one.
    function automatic void push_bundle(input bundle_t b);
        int top;
        top = -1;
        for (int i = 0; i < N; i++) if (b[i].op != MIOP_NOP) top = i;
        for (int i = 0; i < N; i++) begin
            if (b[i].op != MIOP_NOP) exp_q.push_back({b[i], (i == top)});
        end
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rstn = 1'b0;
        bus.bundle_valid = 1'b1;
        bus.bundle       = nop_bundle();
        bus.bundle[`MQ_ARITH] = rand_inst(1'b0);
        bus.issue_ready  = 1'b1;
        bus.flush        = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick;
            checks++;
            if (bus.bundle_ready !== 1'b0) begin
                errors++; $display("FAIL reset_bundle_ready got %b want 0", bus.bundle_ready);
            end
            checks++;
            if (bus.issue_valid !== 1'b0 || bus.issue_last !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL reset_outputs got v=%b l=%b b=%b want 0 0 0",
                                   bus.issue_valid, bus.issue_last, bus.busy);
            end
            checks++;
            if (bus.issue !== '0) begin
                errors++; $display("FAIL reset_issue got %h want 0", bus.issue);
            end
        end
        rstn = 1'b1;
        bus.bundle_valid = 1'b0;
        #1;
        checks++;
        if (bus.bundle_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got %b want 1", bus.bundle_ready);
        end
        tick;
        drive_idle();
    endtask

    task automatic test_basic;
        bundle_t b;
        logic [W-1:0] e;
        b = nop_bundle();
        b[`MQ_LOAD]  = rand_inst(1'b0);
        b[`MQ_ARITH] = rand_inst(1'b0);
        b[`MQ_STORE] = rand_inst(1'b0);
        exp_q.delete();
        push_bundle(b);
        bus.bundle = b; bus.bundle_valid = 1'b1; bus.issue_ready = 1'b1;
        #1;
        checks++;
        if (bus.bundle_ready !== 1'b1 || bus.issue_valid !== 1'b0) begin
            errors++; $display("FAIL basic_accept got rdy=%b v=%b want 1 0", bus.bundle_ready, bus.issue_valid);
        end
        tick;
        bus.bundle_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.issue_valid !== 1'b1) begin
                errors++; $display("FAIL basic_valid[%0d] got %b want 1", k, bus.issue_valid);
            end
            checks++;
            if (bus.issue !== e[W-1:1] || bus.issue_last !== e[0]) begin
                errors++; $display("FAIL basic_op[%0d] got %h/%b want %h/%b",
                                   k, bus.issue, bus.issue_last, e[W-1:1], e[0]);
            end
            tick;
        end
        checks++;
        if (bus.issue_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_done got v=%b busy=%b want 0 0", bus.issue_valid, bus.busy);
        end
        drive_idle();
    endtask

    task automatic test_all_nop;
        bus.bundle = nop_bundle();
        bus.bundle_valid = 1'b1; bus.issue_ready = 1'b1;
        #1;
        checks++;
        if (bus.bundle_ready !== 1'b1) begin
            errors++; $display("FAIL nop_accept got %b want 1", bus.bundle_ready);
        end
        tick;
        bus.bundle_valid = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.issue_valid !== 1'b0 || bus.bundle_ready !== 1'b1 || bus.busy !== 1'b0 || dbg_state !== 1'b0) begin
                errors++; $display("FAIL nop_idle[%0d] got v=%b rdy=%b busy=%b st=%b want 0 1 0 0",
                                   c, bus.issue_valid, bus.bundle_ready, bus.busy, dbg_state);
            end
            tick;
        end
        drive_idle();
    endtask

    task automatic test_backpressure;
        bundle_t b;
        logic [W-1:0] e;
        int pat[5] = '{1, 0, 0, 1, 1};
        int issued;
        miinst_t prev;
        logic prev_hold;
        b = nop_bundle();
        b[`MQ_ARITH] = rand_inst(1'b0);
        b[`MQ_STORE] = rand_inst(1'b0);
        b[`MQ_RSRV2] = rand_inst(1'b0);
        exp_q.delete();
        push_bundle(b);
        issued = 0; prev_hold = 1'b0; prev = '0;
        bus.bundle = b; bus.bundle_valid = 1'b1;
        tick;
        bus.bundle_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.issue_ready = (pat[c] != 0);
            #1;
            checks++;
            if (bus.issue_valid !== 1'b1) begin
                errors++; $display("FAIL bp_valid[%0d] got %b want 1", c, bus.issue_valid);
            end
            if (prev_hold) begin
                checks++;
                if (bus.issue !== prev) begin
                    errors++; $display("FAIL bp_stable[%0d] got %h want %h", c, bus.issue, prev);
                end
            end
            if (bus.issue_valid && bus.issue_ready) begin
                issued++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++;
                if (bus.issue !== e[W-1:1] || bus.issue_last !== e[0]) begin
                    errors++; $display("FAIL bp_op[%0d] got %h/%b want %h/%b",
                                       c, bus.issue, bus.issue_last, e[W-1:1], e[0]);
                end
            end
            prev_hold = bus.issue_valid && !bus.issue_ready;
            prev = bus.issue;
            tick;
        end
        checks++;
        if (bus.issue_valid !== 1'b0 || issued != 3) begin
            errors++; $display("FAIL bp_count got v=%b issued=%0d want 0 3", bus.issue_valid, issued);
        end
        drive_idle();
    endtask

    task automatic test_flush;
        bundle_t b;
        logic [W-1:0] e;
        b = nop_bundle();
        b[`MQ_LOAD]  = rand_inst(1'b0);
        b[`MQ_ARITH] = rand_inst(1'b0);
        b[`MQ_STORE] = rand_inst(1'b0);
        b[`MQ_RSRV3] = rand_inst(1'b0);
        exp_q.delete();
        push_bundle(b);
        bus.bundle = b; bus.bundle_valid = 1'b1; bus.issue_ready = 1'b1;
        tick;
        bus.bundle_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                bus.flush = 1'b1;
                bus.bundle_valid = 1'b1;
                bus.bundle = nop_bundle();
                bus.bundle[`MQ_LOAD] = rand_inst(1'b0);
            end
            #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.issue_valid !== 1'b1 || bus.issue !== e[W-1:1]) begin
                errors++; $display("FAIL flush_op[%0d] got v=%b %h want 1 %h", k, bus.issue_valid, bus.issue, e[W-1:1]);
            end
            tick;
        end
        bus.flush = 1'b0;
        bus.bundle_valid = 1'b0;
        #1;
        checks++;
        if (bus.issue_valid !== 1'b0 || dbg_state !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL flush_idle got v=%b st=%b busy=%b want 0 0 0", bus.issue_valid, dbg_state, bus.busy);
        end
        tick;
        checks++;
        if (bus.issue_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_accept got v=%b want 0", bus.issue_valid);
        end
        exp_q.delete();
        drive_idle();
    endtask

    task automatic test_flush_ready;
        bus.flush = 1'b1;
        bus.bundle_valid = 1'b1;
        bus.bundle = nop_bundle();
        bus.bundle[`MQ_STORE] = rand_inst(1'b0);
        #1;
        checks++;
        if (bus.bundle_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready got %b want 0", bus.bundle_ready);
        end
        tick;
        drive_idle();
        #1;
        checks++;
        if (bus.issue_valid !== 1'b0) begin
            errors++; $display("FAIL flush_ready_drop got v=%b want 0", bus.issue_valid);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        bundle_t a, b;
        logic [W-1:0] e;
        bit a_sent, b_sent;
        int b_acc_cyc, n;
        int iss_cyc[8];
        int exp_cyc[4];
        int exp_b_acc;
`ifdef ISSUER_SKID_EN
        exp_cyc = '{1, 2, 3, 4};
        exp_b_acc = 1;
`else
        exp_cyc = '{1, 2, 4, 5};
        exp_b_acc = 3;
`endif
        a = nop_bundle(); a[`MQ_ARITH] = rand_inst(1'b0); a[`MQ_STORE] = rand_inst(1'b0);
        b = nop_bundle(); b[`MQ_LOAD]  = rand_inst(1'b0); b[`MQ_RSRV1] = rand_inst(1'b0);
        exp_q.delete();
        push_bundle(a);
        push_bundle(b);
        a_sent = 0; b_sent = 0; b_acc_cyc = -1; n = 0;
        bus.issue_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.bundle_valid = !(a_sent && b_sent);
            bus.bundle = a_sent ? b : a;
            #1;
            if (bus.issue_valid && bus.issue_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra cyc %0d got issue %h want none", c, bus.issue);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.issue !== e[W-1:1] || bus.issue_last !== e[0]) begin
                        errors++; $display("FAIL b2b_op cyc %0d got %h/%b want %h/%b",
                                           c, bus.issue, bus.issue_last, e[W-1:1], e[0]);
                    end
                end
                if (n < 8) iss_cyc[n] = c;
                n++;
            end
            if (bus.bundle_valid && bus.bundle_ready) begin
                if (!a_sent) a_sent = 1;
                else begin b_sent = 1; b_acc_cyc = c; end
            end
            tick;
        end
        checks++;
        if (b_acc_cyc != exp_b_acc) begin
            errors++; $display("FAIL b2b_accept got cyc %0d want %0d", b_acc_cyc, exp_b_acc);
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL b2b_count got %0d want 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (iss_cyc[i] != exp_cyc[i]) begin
                    errors++; $display("FAIL b2b_timing[%0d] got cyc %0d want %0d", i, iss_cyc[i], exp_cyc[i]);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_issue;
        bundle_t b;
        logic [W-1:0] e;
        b = nop_bundle();
        b[`MQ_LOAD]  = rand_inst(1'b0);
        b[`MQ_STORE] = rand_inst(1'b0);
        b[`MQ_RSRV1] = rand_inst(1'b0);
        exp_q.delete();
        push_bundle(b);
        bus.bundle = b; bus.bundle_valid = 1'b1; bus.issue_ready = 1'b1;
        tick;
        bus.bundle_valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue !== e[W-1:1]) begin
            errors++; $display("FAIL rstmid_first got v=%b %h want 1 %h", bus.issue_valid, bus.issue, e[W-1:1]);
        end
        tick;
        bus.issue_ready = 1'b0;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.bundle_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_ready got %b want 0", bus.bundle_ready);
        end
        tick;
        checks++;
        if (bus.issue_valid !== 1'b0 || bus.issue_last !== 1'b0 || bus.busy !== 1'b0 ||
            bus.issue !== '0 || dbg_state !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs got v=%b l=%b busy=%b issue=%h st=%b want 0 0 0 0 0",
                               bus.issue_valid, bus.issue_last, bus.busy, bus.issue, dbg_state);
        end
        rstn = 1'b1;
        bus.issue_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if (bus.issue_valid !== 1'b0) begin
                errors++; $display("FAIL rstmid_noissue[%0d] got %b want 0", c, bus.issue_valid);
            end
        end
        exp_q.delete();
        drive_idle();
    endtask

    task automatic test_random;
        bundle_t b;
        logic [W-1:0] e;
        logic prev_hold;
        miinst_t prev;
        int size_before;
        exp_q.delete();
        prev_hold = 1'b0; prev = '0;
        for (int c = 0; c < 660; c++) begin
            if (c < 600) begin
                for (int i = 0; i < N; i++) b[i] = rand_inst($urandom_range(0, 1) == 0);
                bus.bundle       = b;
                bus.bundle_valid = ($urandom_range(0, 9) < 4);
                bus.issue_ready  = ($urandom_range(0, 9) < 7);
                bus.flush        = ($urandom_range(0, 39) == 0);
            end else begin
                b = bus.bundle;
                bus.bundle_valid = 1'b0;
                bus.issue_ready  = 1'b1;
                bus.flush        = 1'b0;
            end
            #1;
            size_before = exp_q.size();
            checks++;
            if (bus.issue_valid !== (size_before != 0)) begin
                errors++; $display("FAIL rand_valid cyc %0d got %b want %b", c, bus.issue_valid, size_before != 0);
            end
            if (prev_hold) begin
                checks++;
                if (bus.issue_valid !== 1'b1 || bus.issue !== prev) begin
                    errors++; $display("FAIL rand_stable cyc %0d got %b/%h want 1/%h", c, bus.issue_valid, bus.issue, prev);
                end
            end
`ifndef ISSUER_SKID_EN
            checks++;
            if (bus.bundle_ready !== (size_before == 0 && !bus.flush) || bus.busy !== (size_before != 0)) begin
                errors++; $display("FAIL rand_ready cyc %0d got rdy=%b busy=%b want %b %b", c,
                                   bus.bundle_ready, bus.busy, size_before == 0 && !bus.flush, size_before != 0);
            end
`endif
            if (bus.issue_valid && bus.issue_ready && size_before != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.issue !== e[W-1:1] || bus.issue_last !== e[0]) begin
                    errors++; $display("FAIL rand_op cyc %0d got %h/%b want %h/%b",
                                       c, bus.issue, bus.issue_last, e[W-1:1], e[0]);
                end
            end
            if (bus.flush) exp_q.delete();
            else if (bus.bundle_valid && bus.bundle_ready) push_bundle(b);
            prev_hold = bus.issue_valid && !bus.issue_ready && !bus.flush;
            prev = bus.issue;
            tick;
        end
        checks++;
        if (exp_q.size() != 0 || bus.issue_valid !== 1'b0) begin
            errors++; $display("FAIL rand_drain got left=%0d v=%b want 0 0", exp_q.size(), bus.issue_valid);
        end
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        drive_idle();
        test_reset();
        test_basic();
        test_all_nop();
        test_backpressure();
        test_flush();
        test_flush_ready();
        test_back_to_back();
        test_reset_mid_issue();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
